// File: rtl/spi_reg_master.sv
// SPI Mode-0 master issuing one 32-bit register read/write frame per request.
// Frame: RW, reserved 0, address, data; MSB first.
module spi_reg_master #(
    parameter int CLK_DIV = 4,
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              SCLK,
    output logic              MOSI,
    output logic              SS,
    input  logic              MISO
);

    localparam int FRAME_W = 2 + ADDR_W + DATA_W;
    localparam int CW      = $clog2(CLK_DIV);
    localparam int BW      = $clog2(FRAME_W);

    if (CLK_DIV < 2) begin : g_div_check
        $error("spi_reg_master: CLK_DIV must be >= 2");
    end

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic                sclk_q, sclk_d;
    logic [FRAME_W-1:0]  tx_q, tx_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic                wr_q, wr_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic accept;
    logic half_done;
    logic shifting;
    logic frame_active;

    assign req_ready    = (state_q == IDLE);
    assign busy         = !req_ready;
    assign accept       = req_valid && req_ready && rst;
    assign half_done    = (cnt_q == CW'(CLK_DIV - 1));
    assign shifting     = (state_q == SETUP) || (state_q == SHIFT);
    assign frame_active = shifting || (state_q == HOLD);

    // SS drops in the accept cycle so a back-to-back frame sees SS high for GAP only
    assign SS        = !(accept || frame_active);
    assign SCLK      = sclk_q;
    assign MOSI      = accept ? req_write : (shifting ? tx_q[FRAME_W-1] : 1'b0);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;

    always_comb begin
        state_d     = state_q;
        bit_d       = bit_q;
        sclk_d      = sclk_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        wr_d        = wr_q;
        rsp_valid_d = 1'b0;
        rdata_d     = rdata_q;
        cnt_d       = (state_q == IDLE || half_done) ? '0 : cnt_q + 1'b1;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    tx_d    = {req_write, 1'b0, req_addr,
                               req_write ? req_wdata : '0};
                    wr_d    = req_write;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (half_done) begin
                    state_d = SHIFT;
                    sclk_d  = 1'b1;
                    bit_d   = '0;
                    rx_d    = {rx_q[DATA_W-2:0], MISO};
                end
            end
            SHIFT: begin
                if (half_done) begin
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        tx_d   = {tx_q[FRAME_W-2:0], 1'b0};
                    end else if (bit_q == BW'(FRAME_W - 1)) begin
                        state_d = HOLD;
                    end else begin
                        bit_d  = bit_q + 1'b1;
                        sclk_d = 1'b1;
                        rx_d   = {rx_q[DATA_W-2:0], MISO};
                    end
                end
            end
            HOLD: begin
                if (half_done) state_d = GAP;
            end
            GAP: begin
                if (half_done) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rdata_d     = wr_q ? '0 : rx_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            sclk_q      <= 1'b0;
            tx_q        <= '0;
            rx_q        <= '0;
            wr_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            sclk_q      <= sclk_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            wr_q        <= wr_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
        end
    end

endmodule

// File: tb/tb_spi_reg_master.sv
// Directed bench for spi_reg_master: vector table plus back-to-back and abort sequences.
// A small SPI slave model captures MOSI on SCLK rises and shifts MISO on SCLK falls.
module tb_spi_reg_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [13:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        busy;
    logic        SCLK;
    logic        MOSI;
    logic        SS;
    logic        MISO;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    spi_reg_master #(.CLK_DIV(4), .ADDR_W(14), .DATA_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .SS        (SS),
        .MISO      (MISO)
    );

    // slave model
    logic [31:0] mosi_sr    = '0;
    int          rise_total = 0;
    int          fall_total = 0;
    int          fall_base  = 0;
    logic [31:0] slave_word = '1;

    always @(posedge SCLK) begin
        mosi_sr    <= {mosi_sr[30:0], MOSI};
        rise_total <= rise_total + 1;
    end

    always @(negedge SCLK) fall_total <= fall_total + 1;
    always @(negedge SS) fall_base <= fall_total;

    always_comb begin
        int d;
        d    = fall_total - fall_base;
        MISO = (d > 31 || d < 0) ? 1'b0 : slave_word[5'(31 - d)];
    end

    typedef struct {
        bit          wr;
        logic [13:0] addr;
        logic [15:0] wdata;
        logic [15:0] sdata;
        logic [31:0] frame;
        logic [15:0] rdata;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic start_req(input vec_t v);
        int k;
        slave_word = {16'hFFFF, v.sdata};
        @(negedge clk);
        req_write = v.wr;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_valid = 1'b1;
        k = 0;
        while (!req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
    endtask

    // Called right after the handshake edge; returns at the negedge of the rsp_valid cycle.
    task automatic run_frame(input bit nv, input vec_t nx,
                             output logic [31:0] frame, output logic [15:0] rdata,
                             output int lat, output int rises, output int rdy_low,
                             output int ss_hi, output int viol);
        int  base;
        bit  to;
        base    = rise_total;
        lat     = 0;
        rdy_low = 0;
        ss_hi   = 0;
        viol    = 0;
        to      = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (i == 0) begin
                req_valid = nv;
                req_write = nx.wr;
                req_addr  = nx.addr;
                req_wdata = nx.wdata;
            end
            if (rsp_valid) begin
                to  = 1'b0;
                lat = i + 1;
                break;
            end
            if (!req_ready) rdy_low++;
            if (SS) ss_hi++;
            if (SS && SCLK) viol++;
            @(posedge clk);
        end
        chk("rsp_timeout", {31'd0, to}, 32'd0);
        frame = mosi_sr;
        rdata = rsp_rdata;
        rises = rise_total - base;
    endtask

    task automatic check_frame(input vec_t v, input logic [31:0] frame,
                               input logic [15:0] rdata, input int lat,
                               input int rises, input int rdy_low, input int viol);
        chk("mosi_frame", frame, v.frame);
        chk("rsp_rdata", {16'd0, rdata}, {16'd0, v.rdata});
        chk("rsp_latency", lat, 269);
        chk("sclk_rises", rises, 32);
        chk("req_ready_low", rdy_low, 268);
        chk("sclk_while_ss_high", viol, 0);
    endtask

    initial begin
        logic [31:0] frame;
        logic [15:0] rdata;
        int          lat, rises, rdy_low, ss_hi, viol, bad, base, k;
        vec_t        none, va, vb;

        vecs[0] = '{1'b1, 14'h0123, 16'hBEEF, 16'h1234, 32'h8123_BEEF, 16'h0000};
        vecs[1] = '{1'b0, 14'h3FFF, 16'hDEAD, 16'h5A5A, 32'h3FFF_0000, 16'h5A5A};
        vecs[2] = '{1'b1, 14'h0000, 16'h0001, 16'hFFFF, 32'h8000_0001, 16'h0000};
        vecs[3] = '{1'b0, 14'h1555, 16'h0000, 16'hA5C3, 32'h1555_0000, 16'hA5C3};
        vecs[4] = '{1'b1, 14'h2AAA, 16'h5555, 16'h0000, 32'hAAAA_5555, 16'h0000};
        none    = '{1'b0, 14'h0, 16'h0, 16'h0, 32'h0, 16'h0};

        rst       = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;

        @(negedge clk);
        chk("rst_ss", {31'd0, SS}, 32'd1);
        chk("rst_sclk", {31'd0, SCLK}, 32'd0);
        chk("rst_mosi", {31'd0, MOSI}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            start_req(vecs[i]);
            run_frame(1'b0, none, frame, rdata, lat, rises, rdy_low, ss_hi, viol);
            check_frame(vecs[i], frame, rdata, lat, rises, rdy_low, viol);
            chk("ss_high_in_frame", ss_hi, 4);
            @(posedge clk);
            @(negedge clk);
            chk("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
            chk("rdata_held", {16'd0, rsp_rdata}, {16'd0, vecs[i].rdata});
        end

        // back-to-back, req_valid held with a changed request during frame A
        va = '{1'b0, 14'h0AAA, 16'hFFFF, 16'h1357, 32'h0AAA_0000, 16'h1357};
        vb = '{1'b1, 14'h3001, 16'hC0DE, 16'hFFFF, 32'hB001_C0DE, 16'h0000};
        start_req(va);
        run_frame(1'b1, vb, frame, rdata, lat, rises, rdy_low, ss_hi, viol);
        check_frame(va, frame, rdata, lat, rises, rdy_low, viol);
        chk("b2b_ready_in_rsp", {31'd0, req_ready}, 32'd1);
        chk("b2b_ss_gap", ss_hi + int'(SS), 4);
        slave_word = {16'hFFFF, vb.sdata};
        @(posedge clk);
        run_frame(1'b0, none, frame, rdata, lat, rises, rdy_low, ss_hi, viol);
        check_frame(vb, frame, rdata, lat, rises, rdy_low, viol);

        // reset in the middle of a write
        start_req(vecs[0]);
        base = rise_total;
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while ((rise_total - base) < 11 && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("abort_reach_bit10", {31'd0, ((rise_total - base) >= 11)}, 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_ss", {31'd0, SS}, 32'd1);
        chk("abort_sclk", {31'd0, SCLK}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_mosi", {31'd0, MOSI}, 32'd0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid) bad++;
        end
        rst = 1'b1;
        repeat (300) begin
            @(negedge clk);
            if (rsp_valid || busy || !SS) bad++;
        end
        chk("abort_quiet", bad, 0);

        start_req(vecs[1]);
        run_frame(1'b0, none, frame, rdata, lat, rises, rdy_low, ss_hi, viol);
        check_frame(vecs[1], frame, rdata, lat, rises, rdy_low, viol);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
